write_buffer: RTL and testbench

Write-data staging buffer for the DDR controller: accepts host write beats (address, data, transaction ID), holds them in order, and drives each beat onto the DRAM data path exactly CWL cycles after the scheduler issues the WRITE command. It is the write-direction counterpart of the read data buffer. It returns a per-write completion carrying the TID. It also offers read-after-write (RAW) forwarding of pending write data to the read path.

---
 rtl/write_buffer_pkg.sv | 23 ++
 rtl/write_buffer_if.sv | 34 +++
 rtl/write_buffer_wr_latency_fsm.sv | 71 +++++++
 rtl/write_buffer.sv | 100 ++++++++++
 tb/tb_write_buffer.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/write_buffer_pkg.sv
// Shared types and default geometry for the DDR write-data staging buffer.
package write_buffer_pkg;

  localparam int WB_DEPTH      = 8;
  localparam int WB_LOG2_DEPTH = 3;
  localparam int WB_DATA_SIZE  = 64;
  localparam int WB_ADDR_SIZE  = 32;
  localparam int WB_TID_SIZE   = 2;
  localparam int WB_CWL        = 5;

  typedef struct packed {
    logic [WB_ADDR_SIZE-1:0] addr;
    logic [WB_DATA_SIZE-1:0] data;
    logic [WB_TID_SIZE-1:0]  tid;
  } write_entry_t;

  typedef logic [1:0] wb_state_t;
  localparam wb_state_t IDLE     = 2'd0;
  localparam wb_state_t WAIT_CWL = 2'd1;
  localparam wb_state_t DRIVE    = 2'd2;
  localparam wb_state_t RESP     = 2'd3;

endpackage

// File: rtl/write_buffer_if.sv
// Host, scheduler, PHY, completion and RAW-lookup signals of the write buffer.
interface write_buffer_if import write_buffer_pkg::*; ();

  logic                    wvalid;
  logic [WB_ADDR_SIZE-1:0] waddr;
  logic [WB_DATA_SIZE-1:0] wdata;
  logic [WB_TID_SIZE-1:0]  wtid;
  logic                    wready;
  logic                    cmd_valid;
  logic [WB_ADDR_SIZE-1:0] cmd_addr;
  logic [WB_TID_SIZE-1:0]  cmd_tid;
  logic                    wr_start;
  logic [WB_DATA_SIZE-1:0] dq_out;
  logic                    dq_oe;
  logic                    bvalid;
  logic [WB_TID_SIZE-1:0]  btid;
  logic                    raw_req;
  logic [WB_ADDR_SIZE-1:0] raw_addr;
  logic                    raw_hit;
  logic [WB_DATA_SIZE-1:0] raw_data;

  modport slave (
    input  wvalid, waddr, wdata, wtid, wr_start, raw_req, raw_addr,
    output wready, cmd_valid, cmd_addr, cmd_tid, dq_out, dq_oe, bvalid, btid,
           raw_hit, raw_data
  );

  modport master (
    output wvalid, waddr, wdata, wtid, wr_start, raw_req, raw_addr,
    input  wready, cmd_valid, cmd_addr, cmd_tid, dq_out, dq_oe, bvalid, btid,
           raw_hit, raw_data
  );

endinterface

// File: rtl/write_buffer_wr_latency_fsm.sv
// Sequences one write: waits CWL cycles after wr_start, drives for one cycle,
// then issues the completion strobe.
module wr_latency_fsm import write_buffer_pkg::*; #(
  parameter int CWL = WB_CWL
) (
  input  logic clk,
  input  logic n_rst,
  input  logic wr_start_i,
  input  logic empty_i,
  output logic idle_o,
  output logic pop_o,
  output logic drive_d_o,
  output logic dq_oe_o,
  output logic bvalid_o
);

  localparam int CNT_W = (CWL > 1) ? $clog2(CWL) : 1;

  wb_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dq_oe_q, bvalid_q;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (wr_start_i && !empty_i) begin
          if (CWL == 1) begin
            state_d = DRIVE;
          end else begin
            state_d = WAIT_CWL;
            cnt_d   = CNT_W'(CWL - 1);
          end
        end
      end
      WAIT_CWL: begin
        if (cnt_q == '0) state_d = DRIVE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DRIVE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dq_oe_q  <= 1'b0;
      bvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dq_oe_q  <= (state_d == DRIVE);
      bvalid_q <= (state_d == RESP);
    end
  end

  assign idle_o    = (state_q == IDLE);
  assign pop_o     = (state_q == DRIVE);
  assign drive_d_o = (state_d == DRIVE);
  assign dq_oe_o   = dq_oe_q;
  assign bvalid_o  = bvalid_q;

endmodule

// File: rtl/write_buffer.sv
// In-order write-data staging FIFO feeding the DRAM data path CWL cycles after
// each WRITE command. Optional read-after-write forwarding via RAW_FWD_EN.
module write_buffer import write_buffer_pkg::*; #(
  parameter int DEPTH      = WB_DEPTH,
  parameter int LOG2_DEPTH = WB_LOG2_DEPTH,
  parameter int CWL        = WB_CWL
) (
  input  logic           clk,
  input  logic           n_rst,
  write_buffer_if.slave  bus
);

  write_entry_t            mem_q [DEPTH];
  logic [LOG2_DEPTH-1:0]   wptr_q, rptr_q;
  logic [LOG2_DEPTH:0]     count_q;
  logic [WB_DATA_SIZE-1:0] dq_out_q;
  logic [WB_TID_SIZE-1:0]  btid_q;
  write_entry_t            head;
  logic full, empty, push, pop, idle, drive_d, dq_oe, bvalid;

  assign full  = (count_q == (LOG2_DEPTH + 1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rptr_q];

  wr_latency_fsm #(.CWL(CWL)) u_fsm (
    .clk        (clk),
    .n_rst      (n_rst),
    .wr_start_i (bus.wr_start),
    .empty_i    (empty),
    .idle_o     (idle),
    .pop_o      (pop),
    .drive_d_o  (drive_d),
    .dq_oe_o    (dq_oe),
    .bvalid_o   (bvalid)
  );

  // A full buffer still accepts the beat that lands in the slot freed by this edge's pop.
  assign bus.wready = !full || pop;
  assign push       = bus.wvalid && bus.wready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      // NOTE: storage is cleared on reset because the head slot is visible on
      // cmd_addr/cmd_tid and must read as zero out of reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      dq_out_q <= '0;
      btid_q   <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= '{addr: bus.waddr, data: bus.wdata, tid: bus.wtid};
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
        btid_q <= head.tid;
      end
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      dq_out_q <= drive_d ? head.data : '0;
    end
  end

  assign bus.cmd_valid = !empty && idle;
  assign bus.cmd_addr  = head.addr;
  assign bus.cmd_tid   = head.tid;
  assign bus.dq_out    = dq_out_q;
  assign bus.dq_oe     = dq_oe;
  assign bus.bvalid    = bvalid;
  assign bus.btid      = btid_q;

`ifdef RAW_FWD_EN
  logic                    raw_match;
  logic [WB_DATA_SIZE-1:0] raw_sel;
  logic [LOG2_DEPTH-1:0]   raw_idx;

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    raw_match = 1'b0;
    raw_sel   = '0;
    raw_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      raw_idx = rptr_q + LOG2_DEPTH'(i);
      if (((LOG2_DEPTH + 1)'(i) < count_q) && (mem_q[raw_idx].addr == bus.raw_addr)) begin
        raw_match = 1'b1;
        raw_sel   = mem_q[raw_idx].data;
      end
    end
  end

  assign bus.raw_hit  = bus.raw_req && raw_match;
  assign bus.raw_data = bus.raw_hit ? raw_sel : '0;
`else
  assign bus.raw_hit  = 1'b0;
  assign bus.raw_data = '0;
`endif

endmodule

// File: tb/tb_write_buffer.sv
// Self-checking bench for write_buffer: queue-based reference model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_write_buffer;
  import write_buffer_pkg::*;

  localparam int DEPTH = WB_DEPTH;
  localparam int CWL   = WB_CWL;
`ifdef RAW_FWD_EN
  localparam bit RAW_ON = 1'b1;
`else
  localparam bit RAW_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  write_buffer_if bus ();

  write_buffer #(.DEPTH(WB_DEPTH), .LOG2_DEPTH(WB_LOG2_DEPTH), .CWL(WB_CWL)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending writes in a queue; 'since' counts edges after an
  // accepted wr_start (-1 when no write is in flight).
  write_entry_t mq[$];
  int           since  = -1;
  logic [1:0]   m_btid = '0;
  bit           cmp_en = 1'b0;

  always @(posedge clk) begin
    if (!n_rst) begin
      mq.delete();
      since  = -1;
      m_btid = '0;
    end else begin
      bit accept, mpop, mpush;
      write_entry_t e;
      accept = (since < 0) && bus.wr_start && (mq.size() > 0);
      mpop   = (since == CWL);
      mpush  = bus.wvalid && ((mq.size() < DEPTH) || mpop);
      if (since >= 0) since++;
      if (mpop) begin
        e      = mq.pop_front();
        m_btid = e.tid;
      end
      if (since == CWL + 2) since = -1;
      if (mpush) mq.push_back('{addr: bus.waddr, data: bus.wdata, tid: bus.wtid});
      if (accept) since = 0;
    end
  end

  always @(posedge clk) begin
    #2;
    if (cmp_en && n_rst) begin
      logic        e_hit;
      logic [63:0] e_data;
      check("wready", bus.wready, (mq.size() < DEPTH) || (since == CWL));
      check("cmd_valid", bus.cmd_valid, (since < 0) && (mq.size() > 0));
      if (mq.size() > 0) begin
        check("cmd_addr", bus.cmd_addr, mq[0].addr);
        check("cmd_tid", bus.cmd_tid, mq[0].tid);
      end
      check("dq_oe", bus.dq_oe, since == CWL);
      if (since == CWL && mq.size() > 0) check("dq_out", bus.dq_out, mq[0].data);
      check("bvalid", bus.bvalid, since == CWL + 1);
      if (since == CWL + 1) check("btid", bus.btid, m_btid);
      e_hit  = 1'b0;
      e_data = '0;
      if (RAW_ON && bus.raw_req) begin
        foreach (mq[i]) begin
          if (mq[i].addr == bus.raw_addr) begin
            e_hit  = 1'b1;
            e_data = mq[i].data;
          end
        end
      end
      check("raw_hit", bus.raw_hit, e_hit);
      check("raw_data", bus.raw_data, e_data);
    end
  end

  task automatic idle_inputs();
    bus.wvalid   = 1'b0;
    bus.waddr    = '0;
    bus.wdata    = '0;
    bus.wtid     = '0;
    bus.wr_start = 1'b0;
    bus.raw_req  = 1'b0;
    bus.raw_addr = '0;
  endtask

  task automatic push_beat(input logic [31:0] a, input logic [63:0] d, input logic [1:0] t);
    bus.wvalid = 1'b1;
    bus.waddr  = a;
    bus.wdata  = d;
    bus.wtid   = t;
    @(negedge clk);
    bus.wvalid = 1'b0;
  endtask

  task automatic drain(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      bus.wr_start = bus.cmd_valid;
      @(negedge clk);
    end
    bus.wr_start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wready"}, bus.wready, 1'b1);
    check({tag, "_cmd_valid"}, bus.cmd_valid, 1'b0);
    check({tag, "_cmd_addr"}, bus.cmd_addr, 32'h0);
    check({tag, "_cmd_tid"}, bus.cmd_tid, 2'd0);
    check({tag, "_dq_oe"}, bus.dq_oe, 1'b0);
    check({tag, "_dq_out"}, bus.dq_out, 64'h0);
    check({tag, "_bvalid"}, bus.bvalid, 1'b0);
    check({tag, "_btid"}, bus.btid, 2'd0);
    check({tag, "_raw_hit"}, bus.raw_hit, 1'b0);
    check({tag, "_raw_data"}, bus.raw_data, 64'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, nb, n_oe, n_bv;
    bit injected, just_injected;
    logic [63:0] dd [10];
    logic [1:0]  bt [10];

    idle_inputs();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    n_rst  = 1'b1;
    cmp_en = 1'b1;

    // Single write, wr_start two cycles after the push.
    push_beat(32'h100, 64'hDEADBEEF, 2'd1);
    check("t1_cmd_valid", bus.cmd_valid, 1'b1);
    check("t1_cmd_addr", bus.cmd_addr, 32'h100);
    @(negedge clk);
    bus.wr_start = 1'b1;
    @(negedge clk);
    bus.wr_start = 1'b0;
    for (int k = 1; k <= CWL + 2; k++) begin
      @(negedge clk);
      check($sformatf("t1_dq_oe_k%0d", k), bus.dq_oe, k == CWL);
      check($sformatf("t1_bvalid_k%0d", k), bus.bvalid, k == CWL + 1);
      if (k == CWL)     check("t1_dq_out", bus.dq_out, 64'hDEADBEEF);
      if (k == CWL + 1) check("t1_btid", bus.btid, 2'd1);
      if (k == CWL + 2) check("t1_cmd_valid_after", bus.cmd_valid, 1'b0);
    end

    // Fill to DEPTH, drop a ninth beat, then drain with a beat pushed on the pop edge.
    for (int i = 0; i < DEPTH; i++) push_beat(32'h200 + 32'(i * 8), 64'(i), 2'(i % 4));
    check("t2_wready_full", bus.wready, 1'b0);
    push_beat(32'h2f0, 64'h9, 2'd0);
    check("t2_wready_after_drop", bus.wready, 1'b0);
    check("t2_head_addr", bus.cmd_addr, 32'h200);
    nd = 0; nb = 0; injected = 1'b0; just_injected = 1'b0;
    for (int c = 0; c < 200 && !(nd == DEPTH + 1 && nb == DEPTH + 1); c++) begin
      bus.wr_start = bus.cmd_valid;
      @(negedge clk);
      bus.wvalid = 1'b0;
      if (just_injected) begin
        check("t3_wready_count_stays_full", bus.wready, 1'b0);
        just_injected = 1'b0;
      end
      if (bus.dq_oe) begin
        if (nd < 10) dd[nd] = bus.dq_out;
        nd++;
        if (!injected) begin
          check("t3_wready_on_pop", bus.wready, 1'b1);
          injected      = 1'b1;
          just_injected = 1'b1;
          bus.wvalid    = 1'b1;
          bus.waddr     = 32'h2f8;
          bus.wdata     = 64'h55;
          bus.wtid      = 2'd3;
        end
      end
      if (bus.bvalid) begin
        if (nb < 10) bt[nb] = bus.btid;
        nb++;
      end
    end
    bus.wr_start = 1'b0;
    check("t2_drive_count", nd, DEPTH + 1);
    check("t2_bvalid_count", nb, DEPTH + 1);
    for (int k = 0; k < DEPTH + 1 && k < nd && k < nb; k++) begin
      check($sformatf("t2_data_%0d", k), dd[k], (k < DEPTH) ? 64'(k) : 64'h55);
      check($sformatf("t2_tid_%0d", k), bt[k], (k < DEPTH) ? 2'(k % 4) : 2'd3);
    end

    // wr_start while empty, then wr_start held through a whole operation.
    n_oe = 0; n_bv = 0;
    bus.wr_start = 1'b1;
    for (int c = 0; c < CWL + 4; c++) begin
      @(negedge clk);
      bus.wr_start = 1'b0;
      if (bus.dq_oe)  n_oe++;
      if (bus.bvalid) n_bv++;
    end
    check("t4_empty_dq_oe", n_oe, 0);
    check("t4_empty_bvalid", n_bv, 0);
    push_beat(32'h180, 64'h1234, 2'd2);
    n_oe = 0; n_bv = 0;
    bus.wr_start = 1'b1;
    for (int c = 0; c < CWL + 8; c++) begin
      @(negedge clk);
      if (bus.dq_oe)  n_oe++;
      if (bus.bvalid) n_bv++;
    end
    bus.wr_start = 1'b0;
    check("t4_busy_dq_oe", n_oe, 1);
    check("t4_busy_bvalid", n_bv, 1);

    // RAW lookup: the younger of two same-address writes must win.
    push_beat(32'h40, 64'hA, 2'd0);
    push_beat(32'h40, 64'hB, 2'd1);
    bus.raw_req  = 1'b1;
    bus.raw_addr = 32'h40;
    #1;
    check("t5_hit_40", bus.raw_hit, RAW_ON);
    check("t5_data_40", bus.raw_data, RAW_ON ? 64'hB : 64'h0);
    bus.raw_addr = 32'h80;
    #1;
    check("t5_hit_80", bus.raw_hit, 1'b0);
    bus.raw_addr = 32'h40;
    drain(2 * (CWL + 3) + 4);
    check("t5_hit_after_pop", bus.raw_hit, 1'b0);
    bus.raw_req = 1'b0;

    // Reset during WAIT_CWL.
    push_beat(32'h300, 64'h77, 2'd2);
    bus.wr_start = 1'b1;
    @(negedge clk);
    bus.wr_start = 1'b0;
    @(negedge clk);
    #1 n_rst = 1'b0;
    #1 check_reset_outputs("t6_wait");
    @(negedge clk);
    n_rst = 1'b1;

    // Reset during DRIVE: dq_oe must fall without waiting for a clock.
    push_beat(32'h340, 64'h88, 2'd3);
    bus.wr_start = 1'b1;
    @(negedge clk);
    bus.wr_start = 1'b0;
    for (int c = 0; c < CWL + 4 && !bus.dq_oe; c++) @(negedge clk);
    check("t6_reached_drive", bus.dq_oe, 1'b1);
    #1 n_rst = 1'b0;
    #1 check_reset_outputs("t6_drive");
    @(negedge clk);
    n_rst = 1'b1;
    n_oe = 0; n_bv = 0;
    for (int c = 0; c < CWL + 4; c++) begin
      @(negedge clk);
      if (bus.dq_oe)  n_oe++;
      if (bus.bvalid) n_bv++;
    end
    check("t6_no_dq_oe_after", n_oe, 0);
    check("t6_no_bvalid_after", n_bv, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      logic [31:0] pool [4];
      pool[0] = 32'h40; pool[1] = 32'h80; pool[2] = 32'hC0; pool[3] = 32'h100;
      bus.wvalid   = ($urandom_range(0, 2) == 0);
      bus.waddr    = pool[$urandom_range(0, 3)];
      bus.wdata    = {$urandom, $urandom};
      bus.wtid     = 2'($urandom_range(0, 3));
      bus.wr_start = ($urandom_range(0, 3) == 0);
      bus.raw_req  = ($urandom_range(0, 1) == 0);
      bus.raw_addr = pool[$urandom_range(0, 3)];
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
